// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: EX-stage operand forwarding and hazard detection with a
// per-register pending scoreboard for long-latency operations.
// Optional feature macro: FWD_PERF_CNT_EN (stall-cause cycle counters).
module fwd_scoreboard #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int NSRC    = 2,
  parameter int MAX_OUT = 4,
  localparam int RW     = $clog2(NREG),
  localparam int CW     = $clog2(MAX_OUT + 1)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NSRC*RW-1:0]   ex_rs,
  input  logic [NSRC-1:0]      ex_rs_used,
  input  logic [RW-1:0]        ex_rd,
  input  logic                 ex_reg_write,
  input  logic                 mem_reg_write,
  input  logic [RW-1:0]        mem_rd,
  input  logic [XLEN-1:0]      mem_data,
  input  logic                 mem_data_ready,
  input  logic                 wb_reg_write,
  input  logic [RW-1:0]        wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 lr_issue_valid,
  input  logic [RW-1:0]        lr_issue_rd,
  output logic                 lr_issue_ready,
  input  logic                 lr_done_valid,
  input  logic [RW-1:0]        lr_done_rd,
  input  logic [XLEN-1:0]      lr_done_data,
  output logic [NSRC*2-1:0]    fwd_sel,
  output logic [NSRC*XLEN-1:0] fwd_data,
  output logic                 stall,
  output logic [NREG-1:0]      busy,
  output logic [CW-1:0]        out_cnt,
  output logic                 sb_err,
  output logic [31:0]          perf_raw,
  output logic [31:0]          perf_load,
  output logic [31:0]          perf_waw
);

  localparam logic [RW-1:0]   RZERO = {RW{1'b0}};
  localparam logic [NREG-1:0] ONE_HOT0 = {{(NREG-1){1'b0}}, 1'b1};

  logic [NREG-1:0] r_busy;
  logic [CW-1:0]   r_out_cnt;
  logic            r_sb_err;

  logic [NSRC-1:0] w_lu;
  logic [NSRC-1:0] w_raw;
  logic            w_waw;
  logic            w_lu_any;
  logic            w_raw_any;
  logic            w_done_hit;
  logic            w_done_err;
  logic            w_cnt_full;
  logic            w_issue_acc;
  logic [NREG-1:0] w_set_mask;
  logic [NREG-1:0] w_clr_mask;
  logic [NREG-1:0] w_busy_nxt;

  // A completion only retires a register that is actually pending; r0 is ignored.
  assign w_done_hit = lr_done_valid & (lr_done_rd != RZERO) & r_busy[lr_done_rd];
  assign w_done_err = lr_done_valid & (lr_done_rd != RZERO) & ~r_busy[lr_done_rd];

  genvar g;
  generate
    for (g = 0; g < NSRC; g = g + 1) begin : g_src
      logic [RW-1:0]   w_rs;
      logic            w_act;
      logic            w_mem_m;
      logic            w_wb_m;
      logic            w_lr_m;
      logic [1:0]      w_sel;
      logic [XLEN-1:0] w_data;

      assign w_rs    = ex_rs[g*RW +: RW];
      assign w_act   = ex_rs_used[g] & (w_rs != RZERO);
      assign w_mem_m = w_act & mem_reg_write & (mem_rd == w_rs);
      assign w_wb_m  = w_act & wb_reg_write & (wb_rd == w_rs);
      assign w_lr_m  = w_act & lr_done_valid & (lr_done_rd == w_rs);

      // Load-use fires on any MEM match whose load data has not returned yet.
      assign w_lu[g]  = w_mem_m & ~mem_data_ready;
      // RAW only when nothing in flight can supply the value and it is pending.
      assign w_raw[g] = w_act & ~w_mem_m & ~w_wb_m & ~w_lr_m & r_busy[w_rs];

      // Operand source priority: MEM, then WB, then LR completion, else regfile.
      always_comb begin
        w_sel  = 2'd0;
        w_data = {XLEN{1'b0}};
        if (w_mem_m) begin
          w_sel  = 2'd1;
          w_data = mem_data;
        end else if (w_wb_m) begin
          w_sel  = 2'd2;
          w_data = wb_data;
        end else if (w_lr_m) begin
          w_sel  = 2'd3;
          w_data = lr_done_data;
        end else begin
          w_sel  = 2'd0;
          w_data = {XLEN{1'b0}};
        end
      end

      assign fwd_sel[g*2 +: 2]     = w_sel;
      assign fwd_data[g*XLEN +: XLEN] = w_data;
    end
  endgenerate

  assign w_lu_any  = |w_lu;
  assign w_raw_any = |w_raw;
  // WAW is cleared when the pending destination completes in this same cycle.
  assign w_waw = ex_reg_write & (ex_rd != RZERO) & r_busy[ex_rd]
               & ~(lr_done_valid & (lr_done_rd == ex_rd));
  assign stall = w_lu_any | w_raw_any | w_waw;

  assign w_cnt_full     = (r_out_cnt == CW'(MAX_OUT));
  assign lr_issue_ready = ~(r_busy[lr_issue_rd] & ~(lr_done_valid & (lr_done_rd == lr_issue_rd)))
                        & ~(w_cnt_full & ~w_done_hit)
                        & ~stall;
  assign w_issue_acc    = lr_issue_valid & lr_issue_ready & (lr_issue_rd != RZERO);

  // Set after clear so a same-cycle issue and completion to one rd leaves it pending.
  assign w_set_mask = w_issue_acc ? (ONE_HOT0 << lr_issue_rd) : {NREG{1'b0}};
  assign w_clr_mask = w_done_hit  ? (ONE_HOT0 << lr_done_rd)  : {NREG{1'b0}};
  assign w_busy_nxt = (r_busy & ~w_clr_mask) | w_set_mask;

  // Scoreboard state: pending bits, outstanding count and sticky protocol error.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_busy    <= {NREG{1'b0}};
      r_out_cnt <= {CW{1'b0}};
      r_sb_err  <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      case ({w_issue_acc, w_done_hit})
        2'b10:   r_out_cnt <= r_out_cnt + CW'(1);
        2'b01:   r_out_cnt <= r_out_cnt - CW'(1);
        default: r_out_cnt <= r_out_cnt;
      endcase
      if (w_done_err) begin
        r_sb_err <= 1'b1;
      end else begin
        r_sb_err <= r_sb_err;
      end
    end
  end

  assign busy    = r_busy;
  assign out_cnt = r_out_cnt;
  assign sb_err  = r_sb_err;

`ifdef FWD_PERF_CNT_EN
  logic [31:0] r_perf_raw;
  logic [31:0] r_perf_load;
  logic [31:0] r_perf_waw;

  // Saturating per-cause stall cycle counters; causes may overlap.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_perf_raw  <= 32'd0;
      r_perf_load <= 32'd0;
      r_perf_waw  <= 32'd0;
    end else begin
      if (w_raw_any && (r_perf_raw != 32'hFFFF_FFFF)) begin
        r_perf_raw <= r_perf_raw + 32'd1;
      end
      if (w_lu_any && (r_perf_load != 32'hFFFF_FFFF)) begin
        r_perf_load <= r_perf_load + 32'd1;
      end
      if (w_waw && (r_perf_waw != 32'hFFFF_FFFF)) begin
        r_perf_waw <= r_perf_waw + 32'd1;
      end
    end
  end

  assign perf_raw  = r_perf_raw;
  assign perf_load = r_perf_load;
  assign perf_waw  = r_perf_waw;
`else
  assign perf_raw  = 32'd0;
  assign perf_load = 32'd0;
  assign perf_waw  = 32'd0;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed self-checking bench for fwd_scoreboard (default parameters).
module tb_fwd_scoreboard;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NSRC = 2;
  localparam int RW   = 5;
  localparam int CW   = 3;

  logic                 clk;
  logic                 rstn;
  logic [NSRC*RW-1:0]   ex_rs;
  logic [NSRC-1:0]      ex_rs_used;
  logic [RW-1:0]        ex_rd;
  logic                 ex_reg_write;
  logic                 mem_reg_write;
  logic [RW-1:0]        mem_rd;
  logic [XLEN-1:0]      mem_data;
  logic                 mem_data_ready;
  logic                 wb_reg_write;
  logic [RW-1:0]        wb_rd;
  logic [XLEN-1:0]      wb_data;
  logic                 lr_issue_valid;
  logic [RW-1:0]        lr_issue_rd;
  logic                 lr_issue_ready;
  logic                 lr_done_valid;
  logic [RW-1:0]        lr_done_rd;
  logic [XLEN-1:0]      lr_done_data;
  logic [NSRC*2-1:0]    fwd_sel;
  logic [NSRC*XLEN-1:0] fwd_data;
  logic                 stall;
  logic [NREG-1:0]      busy;
  logic [CW-1:0]        out_cnt;
  logic                 sb_err;
  logic [31:0]          perf_raw;
  logic [31:0]          perf_load;
  logic [31:0]          perf_waw;

  int n_checks = 0;
  int n_errors = 0;

  fwd_scoreboard dut (
    .clk(clk), .rstn(rstn),
    .ex_rs(ex_rs), .ex_rs_used(ex_rs_used), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_data(mem_data),
    .mem_data_ready(mem_data_ready),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .lr_issue_valid(lr_issue_valid), .lr_issue_rd(lr_issue_rd), .lr_issue_ready(lr_issue_ready),
    .lr_done_valid(lr_done_valid), .lr_done_rd(lr_done_rd), .lr_done_data(lr_done_data),
    .fwd_sel(fwd_sel), .fwd_data(fwd_data), .stall(stall),
    .busy(busy), .out_cnt(out_cnt), .sb_err(sb_err),
    .perf_raw(perf_raw), .perf_load(perf_load), .perf_waw(perf_waw)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ex_rs = '0; ex_rs_used = '0; ex_rd = '0; ex_reg_write = 1'b0;
    mem_reg_write = 1'b0; mem_rd = '0; mem_data = '0; mem_data_ready = 1'b1;
    wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
    lr_issue_valid = 1'b0; lr_issue_rd = '0;
    lr_done_valid = 1'b0; lr_done_rd = '0; lr_done_data = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    step();
  endtask

  initial begin
    idle();
    rstn = 1'b0;
    #12;
    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_cnt", out_cnt, 0);
    chk("rst_err", sb_err, 0);
    chk("rst_stall", stall, 0);
    chk("rst_ready", lr_issue_ready, 1);
    chk("rst_praw", perf_raw, 0);
    rstn = 1'b1;
    step();

    // MEM beats WB for the same register, both operands read r5
    mem_reg_write = 1'b1; mem_rd = 5'd5; mem_data = 32'h11;
    wb_reg_write = 1'b1; wb_rd = 5'd5; wb_data = 32'h22;
    ex_rs = {5'd5, 5'd5}; ex_rs_used = 2'b11;
    #1;
    chk("mem_pri_sel", fwd_sel, 4'b0101);
    chk("mem_pri_data", fwd_data, {32'h11, 32'h11});
    chk("mem_pri_stall", stall, 0);
    mem_reg_write = 1'b0;
    #1;
    chk("wb_sel", fwd_sel, 4'b1010);
    chk("wb_data", fwd_data, {32'h22, 32'h22});
    // r0 is never forwarded even when a stage writes it
    mem_reg_write = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0; ex_rs = {5'd0, 5'd0};
    #1;
    chk("r0_sel", fwd_sel, 4'b0000);
    chk("r0_data", fwd_data, 64'h0);
    idle();
    step();

    // Load-use on r7, then WB supplies it
    mem_reg_write = 1'b1; mem_rd = 5'd7; mem_data_ready = 1'b0;
    wb_reg_write = 1'b1; wb_rd = 5'd7; wb_data = 32'h55;
    ex_rs = {5'd0, 5'd7}; ex_rs_used = 2'b01;
    #1;
    chk("lu_stall", stall, 1);
    chk("lu_ready", lr_issue_ready, 0);
    step();
    mem_reg_write = 1'b0; mem_data_ready = 1'b1; wb_data = 32'h99;
    #1;
    chk("lu_wb_sel", fwd_sel[1:0], 2);
    chk("lu_wb_data", fwd_data[31:0], 32'h99);
    chk("lu_wb_stall", stall, 0);
    idle();
    step();

    // Long-latency issue to r3, RAW stall, then completion forwarding
    lr_issue_valid = 1'b1; lr_issue_rd = 5'd3;
    #1;
    chk("iss3_ready", lr_issue_ready, 1);
    step();
    idle();
    #1;
    chk("iss3_busy", busy[3], 1);
    chk("iss3_cnt", out_cnt, 1);
    ex_rs = {5'd0, 5'd3}; ex_rs_used = 2'b01;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("raw_stall", stall, 1);
      chk("raw_busy3", busy[3], 1);
      step();
    end
    lr_done_valid = 1'b1; lr_done_rd = 5'd3; lr_done_data = 32'hABCD;
    #1;
    chk("lr_sel", fwd_sel[1:0], 3);
    chk("lr_data", fwd_data[31:0], 32'hABCD);
    chk("lr_stall", stall, 0);
    step();
    idle();
    #1;
    chk("lr_busy3_clr", busy[3], 0);
    chk("lr_cnt0", out_cnt, 0);

    // Fill the scoreboard with r1, r2, r3, r6
    lr_issue_valid = 1'b1;
    lr_issue_rd = 5'd1; step();
    lr_issue_rd = 5'd2; step();
    lr_issue_rd = 5'd3; step();
    lr_issue_rd = 5'd6; step();
    idle();
    #1;
    chk("full_busy", busy, 32'h0000_004E);
    chk("full_cnt", out_cnt, 4);
    lr_issue_valid = 1'b1; lr_issue_rd = 5'd4;
    #1;
    chk("full_ready", lr_issue_ready, 0);
    step();
    chk("full_hold", busy, 32'h0000_004E);
    lr_done_valid = 1'b1; lr_done_rd = 5'd1; lr_done_data = 32'h1;
    #1;
    chk("swap_ready", lr_issue_ready, 1);
    step();
    idle();
    #1;
    chk("swap_busy", busy, 32'h0000_005C);
    chk("swap_cnt", out_cnt, 4);
    // Issue to a pending register is refused unless it completes now
    lr_issue_valid = 1'b1; lr_issue_rd = 5'd2;
    #1;
    chk("busyrd_ready", lr_issue_ready, 0);
    idle();
    // WAW on pending r2, cleared by same-cycle completion of r2
    ex_reg_write = 1'b1; ex_rd = 5'd2;
    #1;
    chk("waw_stall", stall, 1);
    lr_done_valid = 1'b1; lr_done_rd = 5'd2;
    #1;
    chk("waw_done_stall", stall, 0);
    idle();
    step();

    // Completion of a non-pending register
    lr_done_valid = 1'b1; lr_done_rd = 5'd9; lr_done_data = 32'h9;
    step();
    idle();
    #1;
    chk("err_set", sb_err, 1);
    chk("err_busy", busy, 32'h0000_005C);
    chk("err_cnt", out_cnt, 4);
    step();
    chk("err_sticky", sb_err, 1);
`ifndef FWD_PERF_CNT_EN
    chk("nperf_raw", perf_raw, 0);
    chk("nperf_load", perf_load, 0);
    chk("nperf_waw", perf_waw, 0);
`endif
    // Asynchronous reset mid-cycle with r2 pending
    rstn = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_cnt", out_cnt, 0);
    chk("arst_err", sb_err, 0);
    #2;
    rstn = 1'b1;
    step();
    lr_done_valid = 1'b1; lr_done_rd = 5'd2;
    step();
    idle();
    #1;
    chk("stale_err", sb_err, 1);
    chk("stale_cnt", out_cnt, 0);

`ifdef FWD_PERF_CNT_EN
    do_reset();
    chk("perf_rst", perf_raw, 0);
    lr_issue_valid = 1'b1; lr_issue_rd = 5'd3;
    step();
    idle();
    ex_rs = {5'd0, 5'd3}; ex_rs_used = 2'b01;
    for (int c = 0; c < 5; c++) begin
      ex_reg_write = (c == 1 || c == 2) ? 1'b1 : 1'b0;
      ex_rd = 5'd3;
      step();
    end
    idle();
    lr_done_valid = 1'b1; lr_done_rd = 5'd3;
    step();
    idle();
    #1;
    chk("perf_raw", perf_raw, 5);
    chk("perf_waw", perf_waw, 2);
    chk("perf_load", perf_load, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised operand-forwarding and hazard unit for the EX stage. Selects each of NSRC source operands from MEM, WB, the long-latency completion port, or the register file. Keeps a per-register pending scoreboard for multi-cycle operations such as the divider and variable-latency loads. Raises a single pipeline stall on RAW, load-use and WAW hazards.

## Interface
Parameters:
- XLEN, 32, data width
- NREG, 32, architectural registers; RW = $clog2(NREG)
- NSRC, 2, source operands checked per cycle
- MAX_OUT, 4, maximum outstanding long-latency ops; CW = $clog2(MAX_OUT+1)

Ports:
- clk  in  1  clock; all state on rising edge
- rstn  in  1  asynchronous active-low reset
- ex_rs  in  NSRC*RW  EX source register indices
- ex_rs_used  in  NSRC  operand actually read
- ex_rd  in  RW  EX destination register
- ex_reg_write  in  1  EX instruction writes ex_rd
- mem_reg_write, mem_rd, mem_data  in  1/RW/XLEN  MEM-stage result
- mem_data_ready  in  1  0 while the MEM result is a load not yet returned
- wb_reg_write, wb_rd, wb_data  in  1/RW/XLEN  WB-stage result
- lr_issue_valid  in  1  long-latency op issued this cycle
- lr_issue_rd  in  RW  its destination
- lr_issue_ready  out  1  issue accepted
- lr_done_valid, lr_done_rd, lr_done_data  in  1/RW/XLEN  long-latency completion
- fwd_sel  out  NSRC*2  per operand: 0 regfile, 1 MEM, 2 WB, 3 LR
- fwd_data  out  NSRC*XLEN  forwarded value; 0 when sel = 0
- stall  out  1  hold IF/ID/EX, bubble into MEM
- busy  out  NREG  pending scoreboard bits
- out_cnt  out  CW  outstanding long-latency ops
- sb_err  out  1  sticky protocol error
- perf_raw, perf_load, perf_waw  out  32 each  stall cycle counters (see Configuration)

## Operation
- Register 0 is never pending, never forwarded, never hazardous. Issue or completion to r0 is ignored.
- Operand i matches stage S when ex_rs_used[i], rs != 0, S writes, and S rd == rs.
- Priority per operand: MEM > WB > LR completion > regfile.
- Load-use stall:
  - Operand matches MEM with mem_data_ready = 0. This fires even if WB or LR also matches.
- RAW stall:
  - The highest-priority source for the operand is regfile, and busy[rs] = 1.
  - A same-cycle lr_done on that rs instead forwards with sel = 3 and does not stall.
- WAW stall:
  - ex_reg_write, ex_rd != 0, busy[ex_rd] = 1, and not completing this cycle.
- stall = OR of the three stall causes.
- lr_issue_ready = 0 when any of these hold:
  - busy[lr_issue_rd] = 1 and there is no same-cycle completion to that rd;
  - out_cnt = MAX_OUT and there is no same-cycle completion;
  - stall = 1.
- Accepted issue (valid and ready): busy[rd] <= 1.
- Completion: busy[rd] <= 0. If the same rd is also issued, set wins.
- out_cnt: +1 on accepted issue, -1 on valid completion of a pending rd, unchanged when both occur.
- Completion of a non-pending rd: busy and out_cnt unchanged, sb_err <= 1. sb_err clears only on reset.

## Timing
- fwd_sel, fwd_data, stall and lr_issue_ready are combinational from current inputs and registered busy/out_cnt. Zero-cycle latency.
- busy and out_cnt update on the clock edge after issue or completion. A completion is visible through the forwarding path in its own cycle.
- Reset (asynchronous, rstn low) sets all of the following to 0:
  - busy, out_cnt, sb_err, perf counters.
  - Combinational outputs then follow the inputs with an empty scoreboard.
- Reset mid-operation discards all pending ops. Later completions for them set sb_err.

## Configuration
- FWD_PERF_CNT_EN defined:
  - perf_raw, perf_load and perf_waw each count cycles in which their cause is active. Multiple causes may count in the same cycle.
  - Counters saturate at 32'hFFFF_FFFF.
- FWD_PERF_CNT_EN undefined: the ports remain, are tied to 0, and no counter flops are synthesised.

## Test plan
- MEM writes r5 = 0x11, WB writes r5 = 0x22, EX reads r5 -> sel = 1, data = 0x11, stall = 0.
- MEM load to r7 with mem_data_ready = 0, EX reads r7 -> stall = 1; next cycle WB has r7 = 0x99 -> sel = 2, data = 0x99, stall = 0.
- Issue to r3, then EX reads r3 for 3 cycles -> stall = 1, busy[3] = 1. lr_done r3 = 0xABCD -> same cycle sel = 3, data = 0xABCD, stall = 0; next cycle busy[3] = 0.
- Issue to r4 with MAX_OUT = 4 and busy = {r1, r2, r3, r6} -> lr_issue_ready = 0. Repeat with a same-cycle completion of r1 -> accepted, out_cnt stays 4.
- lr_done to r9 while not pending -> sb_err = 1 and stays 1. Assert rstn low mid-way with r2 pending -> busy = 0, out_cnt = 0, sb_err = 0.
- With FWD_PERF_CNT_EN: 5-cycle RAW stall plus a 2-cycle WAW overlap -> perf_raw = 5, perf_waw = 2. Without the macro, all perf_* read 0.
